// File: rtl/demux_n_pkg.sv
// Shared types and helpers for the demux_n_deser serial-to-parallel receiver.
// Optional parity stage is enabled with DEMUX_N_DESER_PARITY_EN.
package demux_n_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Zero-extension does not change parity, so one wide helper covers any N.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/demux_n_deser_bit_index_counter.sv
// Bit-position counter for the deserializer: clear, load-to-1 and increment.
// at_last flags the final data position of a frame.
module bit_index_counter #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld1,
  input  logic          en,
  output logic [SW-1:0] idx,
  output logic          at_last
);

  logic [SW-1:0] idx_q;
  logic [SW-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (ld1)
      idx_d = SW'(1);
    else if (en && idx_q != SW'(N - 1))
      idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  assign idx     = idx_q;
  assign at_last = (idx_q == SW'(N - 1));

endmodule

// File: rtl/demux_n_deser.sv
// LSB-first serial-to-parallel receiver with restart-on-sof framing.
// Define DEMUX_N_DESER_PARITY_EN to add a trailing even-parity bit check.
module demux_n_deser
  import demux_n_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int SW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic [N-1:0]  y,
  output logic          y_valid,
  output logic [SW-1:0] idx,
  output logic          busy,
  output logic          frame_err,
`ifdef DEMUX_N_DESER_PARITY_EN
  output logic          parity_err,
`endif
  input  logic          din,
  input  logic          din_valid,
  input  logic          sof
);

  state_e       state_q, state_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] y_q, y_d;
  logic         y_valid_q, y_valid_d;
  logic         frame_err_q, frame_err_d;
  logic         perr_q, perr_d;
  logic         cnt_clr, cnt_ld1, cnt_en;
  logic         at_last;
  logic [SW-1:0] idx_w;
  logic [N-1:0] fresh;

  bit_index_counter #(.N(N)) u_idx (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (cnt_clr),
    .ld1     (cnt_ld1),
    .en      (cnt_en),
    .idx     (idx_w),
    .at_last (at_last)
  );

  assign fresh = {{(N-1){1'b0}}, din};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    y_d         = y_q;
    y_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    perr_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_ld1     = 1'b0;
    cnt_en      = 1'b0;
    if (din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (sof) begin
            shift_d = fresh;
            cnt_ld1 = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sof) begin
            frame_err_d = 1'b1;
            shift_d     = fresh;
            cnt_ld1     = 1'b1;
          end else begin
            shift_d[idx_w] = din;
            if (at_last) begin
              cnt_clr = 1'b1;
`ifdef DEMUX_N_DESER_PARITY_EN
              state_d = ST_PARITY;
`else
              y_d       = shift_d;
              y_valid_d = 1'b1;
              state_d   = ST_IDLE;
`endif
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
`ifdef DEMUX_N_DESER_PARITY_EN
        ST_PARITY: begin
          if (sof) begin
            frame_err_d = 1'b1;
            shift_d     = fresh;
            cnt_ld1     = 1'b1;
            state_d     = ST_SHIFT;
          end else begin
            // din carries the parity bit, not data
            if (din == even_parity(64'(shift_q))) begin
              y_d       = shift_q;
              y_valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      frame_err_q <= frame_err_d;
      perr_q      <= perr_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign idx       = idx_w;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
`ifdef DEMUX_N_DESER_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule
